vga_scan_addr_gen: RTL

//   VGA 640x480@60 timing generator fused with an incremental scaled-image ROM address generator.

---
 rtl/vga_scan_addr_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_addr_gen
// Purpose  : VGA timing generator (default 640x480@60) with an incremental
//            scaled-image ROM address generator. DDA accumulators map each
//            visible pixel onto an IMG_W x IMG_H source image without any
//            multiplier or divider.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_addr_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int IMG_W  = 175,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 17
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_address,
  output logic              line_start,
  output logic              frame_start
);

  localparam int c_H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int c_XACC_W  = $clog2(H_VIS) + 1;
  localparam int c_YACC_W  = $clog2(V_VIS) + 1;

  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOT - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOT - 1);
  localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
  localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
  localparam logic [9:0] c_H_VIS_M1 = 10'(H_VIS - 1);
  localparam logic [9:0] c_V_VIS_M1 = 10'(V_VIS - 1);
  localparam logic [9:0] c_HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  localparam logic [c_XACC_W-1:0] c_IMG_W_X = c_XACC_W'(IMG_W);
  localparam logic [c_XACC_W-1:0] c_H_VIS_X = c_XACC_W'(H_VIS);
  localparam logic [c_YACC_W-1:0] c_IMG_H_Y = c_YACC_W'(IMG_H);
  localparam logic [c_YACC_W-1:0] c_V_VIS_Y = c_YACC_W'(V_VIS);
  localparam logic [ADDR_W-1:0]   c_IMG_W_A = ADDR_W'(IMG_W);

  // Internal state describes the pixel that the next clock edge will present
  // on the outputs, so every output register is loaded from the same pixel.
  logic [9:0]          r_cx;
  logic [9:0]          r_cy;
  logic [c_XACC_W-1:0] r_xacc;
  logic [c_YACC_W-1:0] r_yacc;
  logic [ADDR_W-1:0]   r_sx;
  logic [ADDR_W-1:0]   r_row_base;

  logic                w_end_line;
  logic                w_end_frame;
  logic                w_vis;
  logic [c_XACC_W-1:0] w_xsum;
  logic [c_YACC_W-1:0] w_ysum;

  assign w_end_line  = (r_cx == c_H_LAST);
  assign w_end_frame = w_end_line && (r_cy == c_V_LAST);
  assign w_vis       = (r_cx < c_H_VIS) && (r_cy < c_V_VIS);
  // Accumulator is always below the visible size before the add, so the sum
  // stays under twice the visible size and fits the widened accumulator.
  assign w_xsum      = r_xacc + c_IMG_W_X;
  assign w_ysum      = r_yacc + c_IMG_H_Y;

  // Raster position counters: column wraps per line, line wraps per frame.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_end_line) begin
      r_cx <= '0;
      r_cy <= (r_cy == c_V_LAST) ? 10'd0 : r_cy + 10'd1;
    end else begin
      r_cx <= r_cx + 10'd1;
    end
  end

  // Horizontal DDA: source column advances by IMG_W/H_VIS per visible pixel.
  // The step after the last visible pixel is skipped so sx never reaches IMG_W.
  always_ff @(posedge vga_clk) begin
    if (!reset_n || w_end_line) begin
      r_xacc <= '0;
      r_sx   <= '0;
    end else if (r_cx < c_H_VIS_M1) begin
      if (w_xsum >= c_H_VIS_X) begin
        r_xacc <= w_xsum - c_H_VIS_X;
        r_sx   <= r_sx + ADDR_W'(1);
      end else begin
        r_xacc <= w_xsum;
      end
    end
  end

  // Vertical DDA: source row advances by IMG_H/V_VIS per visible line and the
  // row base tracks sy*IMG_W by repeated addition.
  always_ff @(posedge vga_clk) begin
    if (!reset_n || w_end_frame) begin
      r_yacc     <= '0;
      r_row_base <= '0;
    end else if (w_end_line && (r_cy < c_V_VIS_M1)) begin
      if (w_ysum >= c_V_VIS_Y) begin
        r_yacc     <= w_ysum - c_V_VIS_Y;
        r_row_base <= r_row_base + c_IMG_W_A;
      end else begin
        r_yacc     <= w_ysum;
      end
    end
  end

  // Output registers, all loaded from the same pixel position.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      rom_address <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= !((r_cx >= c_HS_BEG) && (r_cx < c_HS_END));
      vs          <= !((r_cy >= c_VS_BEG) && (r_cy < c_VS_END));
      blank       <= w_vis;
      DrawX       <= r_cx;
      DrawY       <= r_cy;
      rom_address <= w_vis ? (r_row_base + r_sx) : '0;
      line_start  <= (r_cx == 10'd0);
      frame_start <= (r_cx == 10'd0) && (r_cy == 10'd0);
    end
  end

endmodule
`default_nettype wire
